// File: rtl/tx_frame_controller_pkg.sv
// Shared types and constants for the TX frame controller and its occupancy counter.
package tx_frame_controller_pkg;

    localparam int MAX_POINT = 9;
    localparam int MAX_OCC   = 1024;

    typedef struct packed {
        logic       ifft;
        logic [3:0] point;
        logic [3:0] final_shift;
    } cont_to_tx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    function automatic logic point_legal(input logic [3:0] point);
        return (point >= 4'd1) && (point <= 4'(MAX_POINT));
    endfunction

endpackage

// File: rtl/tx_occ_counter.sv
// Output-buffer occupancy up/down counter with sticky overflow/underflow detection.
module tx_occ_counter
    import tx_frame_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_ready,
    input  logic        pop,
    output logic [10:0] occupancy,
    output logic [10:0] occ_next,
    output logic        err_ovf,
    output logic        err_unf
);

    logic wr_ok;
    logic pop_ok;

    assign wr_ok  = in_valid && in_ready && (occupancy < 11'(MAX_OCC));
    assign pop_ok = pop && (occupancy != 11'd0);

    always_comb begin
        occ_next = occupancy;
        if (wr_ok && !pop_ok)
            occ_next = occupancy + 11'd1;
        else if (!wr_ok && pop_ok)
            occ_next = occupancy - 11'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy <= 11'd0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            occupancy <= occ_next;
            if (in_valid && !in_ready)
                err_ovf <= 1'b1;
            if (pop && (occupancy == 11'd0))
                err_unf <= 1'b1;
        end
    end

endmodule

// File: rtl/tx_frame_controller.sv
// TX frame controller: applies frame configs only on frame boundaries with an empty buffer.
// Optional watchdog (err_timeout port) enabled by defining TX_CTRL_TIMEOUT_EN.
module tx_frame_controller
    import tx_frame_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_ifft,
    input  logic [3:0]  cfg_point,
    input  logic [3:0]  cfg_shift,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        pop,
    output logic        tx_ifft,
    output logic [3:0]  tx_point,
    output logic [3:0]  tx_final_shift,
    output logic [10:0] occupancy,
    output logic        busy,
    output logic        err_cfg,
    output logic        err_ovf,
    output logic        err_unf
`ifdef TX_CTRL_TIMEOUT_EN
    ,
    output logic        err_timeout
`endif
);

    state_t      state, state_nx;
    cont_to_tx_t cur, cur_nx, pend, pend_nx, cfg_new;
    logic [8:0]  wcnt, wcnt_nx;
    logic        err_cfg_nx;
    logic [10:0] occ_next;
    logic [10:0] cap;
    logic [9:0]  n_pts;
    logic        wr_ok, wc_last, cfg_fire, cfg_ok;

    tx_occ_counter u_occ (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pop       (pop),
        .occupancy (occupancy),
        .occ_next  (occ_next),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    assign cap      = 11'd2 << cur.point;
    assign n_pts    = 10'd1 << cur.point;
    assign wr_ok    = in_valid && in_ready;
    assign wc_last  = ({1'b0, wcnt} == (n_pts - 10'd1));
    assign cfg_fire = cfg_valid && cfg_ready;
    assign cfg_ok   = point_legal(cfg_point);
    assign cfg_new  = '{ifft: cfg_ifft, point: cfg_point, final_shift: cfg_shift};

    assign cfg_ready = (state == IDLE) || (state == ACTIVE);
    assign in_ready  = ((state == ACTIVE) || (state == STALL)) && (occupancy < cap)
                       && !((state == STALL) && (wcnt == 9'd0));

    always_comb begin
        state_nx   = state;
        cur_nx     = cur;
        pend_nx    = pend;
        wcnt_nx    = wcnt;
        err_cfg_nx = cfg_fire && !cfg_ok;
        if (wr_ok)
            wcnt_nx = wc_last ? 9'd0 : wcnt + 9'd1;
        case (state)
            IDLE: begin
                if (cfg_fire && cfg_ok) begin
                    cur_nx   = cfg_new;
                    state_nx = ACTIVE;
                    wcnt_nx  = 9'd0;
                end
            end
            ACTIVE: begin
                if (cfg_fire && cfg_ok) begin
                    pend_nx = cfg_new;
                    if ((wcnt == 9'd0) && (occupancy == 11'd0))
                        cur_nx = cfg_new;
                    else if (wcnt == 9'd0)
                        state_nx = DRAIN;
                    else
                        state_nx = STALL;
                end
            end
            STALL: begin
                // A wrap on the same cycle the config arrived leaves write_cnt at 0 here.
                if ((wcnt == 9'd0) || (wr_ok && wc_last))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                // Apply on the edge where the buffer becomes empty.
                if ((occupancy == 11'd0) || ((occupancy == 11'd1) && pop)) begin
                    cur_nx   = pend;
                    state_nx = ACTIVE;
                    wcnt_nx  = 9'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            pend    <= '0;
            wcnt    <= 9'd0;
            err_cfg <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cur     <= cur_nx;
            pend    <= pend_nx;
            wcnt    <= wcnt_nx;
            err_cfg <= err_cfg_nx;
            busy    <= (state_nx != IDLE) || (occ_next != 11'd0);
        end
    end

    assign tx_ifft        = cur.ifft;
    assign tx_point       = cur.point;
    assign tx_final_shift = cur.final_shift;

`ifdef TX_CTRL_TIMEOUT_EN
    logic [11:0] wd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd          <= 12'd0;
            err_timeout <= 1'b0;
        end else if (pop) begin
            wd <= 12'd0;
        end else if (occupancy != 11'd0) begin
            if (wd != 12'hFFF)
                wd <= wd + 12'd1;
            if (wd >= 12'hFFE)
                err_timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_frame_controller.sv
// Self-checking bench for tx_frame_controller: reset, vector table with scoreboard, STALL/DRAIN and error sequences.
module tb_tx_frame_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ifft = 1'b0;
    logic [3:0]  cfg_point = 4'd0;
    logic [3:0]  cfg_shift = 4'd0;
    logic        in_valid = 1'b0;
    logic        pop = 1'b0;
    logic        cfg_ready, in_ready, tx_ifft, busy, err_cfg, err_ovf, err_unf;
    logic [3:0]  tx_point, tx_final_shift;
    logic [10:0] occupancy;
`ifdef TX_CTRL_TIMEOUT_EN
    logic        err_timeout;
`endif

    tx_frame_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_ifft       (cfg_ifft),
        .cfg_point      (cfg_point),
        .cfg_shift      (cfg_shift),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pop            (pop),
        .tx_ifft        (tx_ifft),
        .tx_point       (tx_point),
        .tx_final_shift (tx_final_shift),
        .occupancy      (occupancy),
        .busy           (busy),
        .err_cfg        (err_cfg),
        .err_ovf        (err_ovf),
        .err_unf        (err_unf)
`ifdef TX_CTRL_TIMEOUT_EN
        ,
        .err_timeout    (err_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        pp;
        logic [10:0] occ;
        logic        ir;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_occ   = 0;
    logic m_ovf   = 1'b0;
    logic m_unf   = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result for point=3 (capacity 16) after one cycle of the given inputs.
    task automatic add_vec(input logic iv, input logic pp);
        vec_t v;
        logic acc, pok;
        acc = iv && (m_occ < 16);
        pok = pp && (m_occ > 0);
        if (iv && !acc) m_ovf = 1'b1;
        if (pp && m_occ == 0) m_unf = 1'b1;
        m_occ = m_occ + int'(acc) - int'(pok);
        v.iv = iv; v.pp = pp; v.occ = 11'(m_occ); v.ir = (m_occ < 16);
        v.ovf = m_ovf; v.unf = m_unf;
        vecs.push_back(v);
    endtask

    task automatic send_cfg(input logic [3:0] pt, input logic [3:0] sh);
        cfg_valid = 1'b1; cfg_point = pt; cfg_shift = sh; cfg_ifft = 1'b0;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic write1();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t e;
        // Reset state
        rst_n = 1'b0;
        step(); step();
        check("rst_tx_point", tx_point, 0);
        check("rst_tx_shift", tx_final_shift, 0);
        check("rst_tx_ifft", tx_ifft, 0);
        check("rst_occ", occupancy, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {err_cfg, err_ovf, err_unf}, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        step();
        check("idle_cfg_ready", cfg_ready, 1);

        // First config: 1-cycle latency to tx_* and ACTIVE
        send_cfg(4'd3, 4'd2);
        check("cfg_tx_point", tx_point, 3);
        check("cfg_tx_shift", tx_final_shift, 2);
        check("cfg_in_ready", in_ready, 1);
        check("cfg_busy", busy, 1);

        // Vector table: fill, pop, write+pop, underflow, refill, overflow
        for (int i = 0; i < 16; i++) add_vec(1'b1, 1'b0);
        for (int i = 0; i < 11; i++) add_vec(1'b0, 1'b1);
        add_vec(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b1);
        add_vec(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) add_vec(1'b1, 1'b0);
        add_vec(1'b1, 1'b0);

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv;
            pop      = vecs[i].pp;
            sb.push_back(vecs[i]);
            step();
            e = sb.pop_front();
            check($sformatf("vec%0d_occ", i), occupancy, e.occ);
            check($sformatf("vec%0d_in_ready", i), in_ready, e.ir);
            check($sformatf("vec%0d_ovf", i), err_ovf, e.ovf);
            check($sformatf("vec%0d_unf", i), err_unf, e.unf);
        end
        in_valid = 1'b0;
        pop      = 1'b0;

        // Illegal config: consumed, err_cfg pulses, tx_* unchanged
        check("bad_cfg_ready", cfg_ready, 1);
        send_cfg(4'd12, 4'd5);
        check("bad_err_cfg", err_cfg, 1);
        check("bad_tx_point", tx_point, 3);
        check("bad_tx_shift", tx_final_shift, 2);
        check("bad_cfg_ready_after", cfg_ready, 1);
        step();
        check("bad_err_cfg_pulse", err_cfg, 0);

        // Reset mid-frame clears counts and sticky flags
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst2_occ", occupancy, 0);
        check("rst2_errs", {err_cfg, err_ovf, err_unf}, 0);
        check("rst2_tx_point", tx_point, 0);
        check("rst2_busy", busy, 0);

        // Config change mid-frame: STALL, finish frame, DRAIN, apply on empty
        send_cfg(4'd3, 4'd0);
        for (int i = 0; i < 3; i++) write1();
        check("pre_stall_occ", occupancy, 3);
        send_cfg(4'd4, 4'd1);
        check("stall_cfg_ready", cfg_ready, 0);
        check("stall_tx_point", tx_point, 3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_in_ready%0d", i), in_ready, 1);
            write1();
        end
        check("drain_in_ready", in_ready, 0);
        check("drain_occ", occupancy, 8);
        check("drain_cfg_ready", cfg_ready, 0);
        check("drain_tx_point", tx_point, 3);
        for (int i = 0; i < 8; i++) begin
            pop = 1'b1;
            step();
            pop = 1'b0;
            if (i < 7) begin
                check($sformatf("drain_hold%0d", i), tx_point, 3);
            end else begin
                check("apply_tx_point", tx_point, 4);
                check("apply_tx_shift", tx_final_shift, 1);
                check("apply_occ", occupancy, 0);
                check("apply_in_ready", in_ready, 1);
                check("apply_cfg_ready", cfg_ready, 1);
                check("apply_busy", busy, 1);
            end
        end
        check("final_errs", {err_ovf, err_unf}, 0);

`ifdef TX_CTRL_TIMEOUT_EN
        write1();
        repeat (4000) step();
        check("wd_early", err_timeout, 0);
        repeat (100) step();
        check("wd_fire", err_timeout, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_controller.md
TX_FRAME_CONTROLLER -- requirements
Module: tx_frame_controller

Interface
REQ-001 clk  input  1  System clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  Reset, synchronous, active-low.
REQ-003 cfg_valid  input  1  Host offers a new frame configuration.
REQ-004 cfg_ready  output  1  Controller accepts the offer; a transfer occurs when cfg_valid and cfg_ready are both high.
REQ-005 cfg_ifft / cfg_point / cfg_shift  input  1/4/4  Offered IFFT flag, log2 of the point count, and final left shift.
REQ-006 in_valid  input  1  One sample was written into the output buffer this cycle.
REQ-007 in_ready  output  1  Upstream may present a sample.
REQ-008 pop  input  1  The output buffer popped one sample (tx_to_cont.valid).
REQ-009 tx_ifft / tx_point / tx_final_shift  output  1/4/4  Applied configuration (the cont_to_tx fields).
REQ-010 occupancy  output  11  Number of samples held in the buffer, 0..1024.
REQ-011 busy  output  1  High whenever state is not IDLE or occupancy is nonzero.
REQ-012 err_cfg / err_ovf / err_unf  output  1 each  Bad-config pulse, sticky overflow flag, sticky underflow flag.

Function
REQ-013 States: IDLE (no configuration applied), ACTIVE (accepting samples), STALL (new configuration pending; finishing the current frame), DRAIN (waiting for the buffer to empty).
REQ-014 N = 2^tx_point; capacity = 2N (ping-pong).
REQ-015 cfg_ready is 1 in IDLE; 1 in ACTIVE when no configuration is pending; 0 in STALL and DRAIN.
REQ-016 A config with cfg_point outside 1..9 is consumed, err_cfg pulses for 1 cycle, and state and tx_* are unchanged.
REQ-017 A legal config accepted in IDLE drives tx_* and moves to ACTIVE on the next cycle (1-cycle latency).
REQ-018 A legal config accepted in ACTIVE is stored as pending.
- If write_cnt==0 and occupancy==0, it is applied next cycle (stay ACTIVE).
- If write_cnt==0 and occupancy>0, go to DRAIN.
- Otherwise go to STALL.
REQ-019 in_ready = (state==ACTIVE or STALL) and occupancy<2N and not (STALL with write_cnt==0).
REQ-020 write_cnt (9 bits) increments on in_valid&&in_ready and wraps to 0 at N-1.
REQ-021 When STALL's frame completes (write_cnt wraps), go to DRAIN.
REQ-022 In DRAIN, the cycle occupancy reaches 0 the pending config is applied to tx_*; next state is ACTIVE with write_cnt=0.
REQ-023 occupancy update per cycle: +1 on an accepted write, -1 on pop, unchanged when both occur.
REQ-024 in_valid while in_ready=0: sample is not counted; err_ovf is set (sticky).
REQ-025 pop while occupancy==0: ignored; err_unf is set (sticky).
REQ-026 tx_* never change while occupancy>0 or write_cnt!=0.
REQ-027 All outputs are registered except cfg_ready and in_ready, which are combinational from state and registers only (no input-to-output path).

Reset
REQ-028 With rst_n=0 at an edge: state=IDLE, tx_ifft=0, tx_point=0, tx_final_shift=0, occupancy=0, write_cnt=0, pending cleared, all err flags 0, busy=0.
REQ-029 Reset mid-frame or mid-drain discards the pending config and all counts, with no residual error flags.

Configuration
REQ-030 Macro TX_CTRL_TIMEOUT_EN.
- Defined: a 12-bit watchdog counts cycles with occupancy>0 and no pop. At 4095 it sets sticky output err_timeout. The watchdog clears on pop or reset.
- Undefined: the watchdog logic and the err_timeout port are absent.

Structure
REQ-031 Shared package holds:
- the CONT_TO_TX struct (ifft, point, final_shift);
- the state enum;
- constants MAX_POINT=9, MAX_OCC=1024.
REQ-032 One sub-module, tx_occ_counter, holds the occupancy up/down counter and the overflow/underflow detection.

Verification
REQ-033 Reset, then cfg{point=3, shift=2} -> next cycle tx_point=3, tx_final_shift=2, in_ready=1.
REQ-034 With point=3: write 16 samples with no pops -> occupancy=16, in_ready=0; one pop -> occupancy=15, in_ready=1.
REQ-035 Simultaneous write+pop at occupancy=5 -> occupancy stays 5; pop at occupancy 0 -> err_unf=1, occupancy stays 0.
REQ-036 cfg{point=4} offered after 3 of 8 writes with point=3 -> STALL.
- in_ready stays 1 for 5 more writes, then DRAIN.
- tx_point becomes 4 the cycle after the last pop.
REQ-037 cfg{point=12} -> err_cfg pulses 1 cycle, tx_point unchanged; in_valid while in_ready=0 -> err_ovf=1.
REQ-038 With TX_CTRL_TIMEOUT_EN: occupancy=1 and no pop for 4095 cycles -> err_timeout=1.
